i2c_req_arbiter: RTL and testbench
==================================

// Module: i2c_req_arbiter
// PURPOSE
//  Shares one i2c_master_logic instance between NREQ on-chip requesters in the clk_12m domain.
//  Each requester posts one I2C transaction: mode, device address, register address, write data.
//  The block grants round-robin, drives the master's config/address/data inputs and waits for
//  the master's completion flag. It then returns read data plus a done/err pulse to the winner.
//  Replaces hard-wired one-shot config sequencing as the single owner of the master's config inputs.
// PARAMETERS
//  NREQ         4      number of requesters (2..8)
//  TIMEOUT_CYC  24000  max clk_12m cycles in RUN before aborting (2 ms)
//  GAP_CYC      12     cycles m_config is held at I2C_Wait between transactions
// PORTS
//  clk_12m     in   1        system clock, 12 MHz
//  rst_n       in   1        asynchronous, active-low reset
//  req         in   NREQ     level request; held until matching done pulse
//  req_mode    in   8*NREQ   I2C mode per requester, slice [8i+7:8i]
//  req_dev     in   7*NREQ   7-bit device address per requester
//  req_reg     in   8*NREQ   register address per requester
//  req_wdata   in   8*NREQ   write data per requester
//  gnt         out  NREQ     one-hot grant, held from GRANT to end of RUN
//  done        out  NREQ     1-cycle completion pulse to the granted requester
//  err         out  1        valid with done: 1 = timeout or illegal mode
//  rdata       out  8        read byte, valid with done (0 for write modes)
//  busy        out  1        high whenever FSM is not IDLE
//  m_config    out  8        to master i2c_config
//  m_dev_addr  out  7        to master device address
//  m_reg_addr  out  8        to master register address
//  m_wr_data   out  8        to master write data
//  m_rd_data   in   8        from master read data; stable once m_done rises
//  m_done      in   1        master completion flag, i2c_clk domain; high for >=1 i2c_clk period
// BEHAVIOUR
//  Reset: all outputs 0, m_config=I2C_Wait (0x00), rr pointer=0, FSM=IDLE.
//  FSM: IDLE -> GRANT -> RUN -> GAP -> IDLE.
//  IDLE: if any req, pick first set bit at or after the pointer (wrap-around); go to GRANT next cycle.
//  GRANT (1 cycle): gnt asserted; the winner's fields are registered.
//    Legal modes 0x01..0x06 drive m_* and go to RUN.
//    Mode 0x00 or >0x06: skip RUN; pulse done with err=1, go to GAP; the bus is not touched.
//  Latency: req at cycle t in IDLE -> gnt and m_* valid at t+2 (arbitration t+1 registered).
//  RUN: m_done passes through a 2-FF synchroniser and rising-edge detector.
//    The detector arms only after synced m_done is seen low inside RUN, so a stale high is ignored.
//    On an armed edge: rdata<=m_rd_data (0 for modes 1..3), done pulse, err=0, then GAP.
//    Timeout counter reaching TIMEOUT_CYC-1: done pulse, err=1, rdata=0, then GAP.
//    Edge and timeout in the same cycle: edge wins, err=0.
//  GAP: gnt cleared; m_config=I2C_Wait; m_dev/m_reg/m_wr hold; count GAP_CYC cycles, then IDLE.
//    Pointer = winner+1 mod NREQ.
//  A req dropped mid-transaction is ignored; the transaction completes and done still pulses.
//  A req still high after done is a new request and is re-arbitrated fairly.
//  Reset mid-RUN: immediate return to reset values; master sees I2C_Wait.
// STRUCTURE
//  i2c_pkg: mode constants I2C_WAIT..I2C_READ_DIRECTLY (0x00..0x06), MODE_IS_READ function.
//  Sub-module i2c_sync_edge: 2-FF synchroniser plus rising-edge pulse, async active-low reset.
// TESTING
//  1. req[0]=1, mode 0x01, dev 0x50, reg 0x00, wdata 0x11; m_done after 300 cyc
//     -> m_config=0x01 at t+2; done[0] pulse; err=0; then 12 cyc at 0x00.
//  2. req=4'b1111 all mode 0x04 -> grant order 0,1,2,3; next round restarts at 0;
//     rdata = each m_rd_data (0xA5, 0x5A, 0x3C, 0xC3).
//  3. req[2] with mode 0x07 -> no m_config change; done[2] and err=1 two cycles after req.
//  4. m_done never rises -> done with err=1 exactly TIMEOUT_CYC cycles into RUN.
//  5. m_done already high at GRANT, falls, then rises -> only the second edge completes.
//  6. rst_n low during RUN -> all outputs 0 in the same cycle; next req is arbitrated from pointer 0.

Source files
------------

// File: rtl/i2c_pkg.sv
// I2C master mode encodings and arbiter state type shared by the request arbiter.
// Modes 1..3 are writes, 4..6 are reads; 0 parks the master.
package i2c_pkg;

    localparam logic [7:0] I2C_WAIT           = 8'h00;
    localparam logic [7:0] I2C_WRITE_REG      = 8'h01;
    localparam logic [7:0] I2C_WRITE_DIRECTLY = 8'h02;
    localparam logic [7:0] I2C_WRITE_BURST    = 8'h03;
    localparam logic [7:0] I2C_READ_REG       = 8'h04;
    localparam logic [7:0] I2C_READ_BURST     = 8'h05;
    localparam logic [7:0] I2C_READ_DIRECTLY  = 8'h06;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_RUN   = 2'd2,
        S_GAP   = 2'd3
    } arb_state_e;

    function automatic logic MODE_IS_READ(input logic [7:0] mode);
        return (mode >= I2C_READ_REG) && (mode <= I2C_READ_DIRECTLY);
    endfunction

    function automatic logic MODE_IS_LEGAL(input logic [7:0] mode);
        return (mode >= I2C_WRITE_REG) && (mode <= I2C_READ_DIRECTLY);
    endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchroniser for a slow-domain level, plus a one-cycle rising-edge pulse
// taken on the synchronised side.
module i2c_sync_edge (
    input  logic clk_12m,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise
);

    logic ff1, ff2, ff3;

    always_ff @(posedge clk_12m or negedge rst_n) begin
        if (!rst_n) begin
            ff1 <= 1'b0;
            ff2 <= 1'b0;
            ff3 <= 1'b0;
        end else begin
            ff1 <= d;
            ff2 <= ff1;
            ff3 <= ff2;
        end
    end

    assign q    = ff2;
    assign rise = ff2 & ~ff3;

endmodule

// File: rtl/i2c_req_arbiter.sv
// Round-robin owner of a single I2C master: arbitrates NREQ requesters, drives the
// master's config inputs for the winner, and returns done/err/rdata on completion.
module i2c_req_arbiter
    import i2c_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int TIMEOUT_CYC = 24000,
    parameter int GAP_CYC     = 12
) (
    input  logic              clk_12m,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_mode,
    input  logic [7*NREQ-1:0] req_dev,
    input  logic [8*NREQ-1:0] req_reg,
    input  logic [8*NREQ-1:0] req_wdata,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic              err,
    output logic [7:0]        rdata,
    output logic              busy,
    output logic [7:0]        m_config,
    output logic [6:0]        m_dev_addr,
    output logic [7:0]        m_reg_addr,
    output logic [7:0]        m_wr_data,
    input  logic [7:0]        m_rd_data,
    input  logic              m_done
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int GW = $clog2(GAP_CYC + 1);

    logic [NREQ-1:0][7:0] mode_a, reg_a, wdata_a;
    logic [NREQ-1:0][6:0] dev_a;

    assign mode_a  = req_mode;
    assign reg_a   = req_reg;
    assign wdata_a = req_wdata;
    assign dev_a   = req_dev;

    arb_state_e      state;
    logic [PW-1:0]   ptr, win, pick;
    logic            pick_vld;
    logic [NREQ-1:0] win_oh;
    logic [7:0]      cur_mode, cur_reg, cur_wdata;
    logic [6:0]      cur_dev;
    logic [TW-1:0]   tmo_cnt;
    logic [GW-1:0]   gap_cnt;
    logic            armed;
    logic            mdone_s, mdone_rise;
    logic            hit, tmo;
    int              idx;

    i2c_sync_edge u_sync (
        .clk_12m (clk_12m),
        .rst_n   (rst_n),
        .d       (m_done),
        .q       (mdone_s),
        .rise    (mdone_rise)
    );

    // Wrap-around search: first requester at or after the pointer.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        idx      = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!pick_vld && req[idx]) begin
                pick     = PW'(idx);
                pick_vld = 1'b1;
            end
        end
    end

    assign win_oh = NREQ'(1) << win;
    assign busy   = (state != S_IDLE);
    // A completion edge only counts once the synchronised flag was seen low in RUN.
    assign hit    = armed & mdone_rise;
    assign tmo    = (tmo_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_12m or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            ptr        <= '0;
            win        <= '0;
            cur_mode   <= '0;
            cur_reg    <= '0;
            cur_wdata  <= '0;
            cur_dev    <= '0;
            tmo_cnt    <= '0;
            gap_cnt    <= '0;
            armed      <= 1'b0;
            gnt        <= '0;
            done       <= '0;
            err        <= 1'b0;
            rdata      <= '0;
            m_config   <= I2C_WAIT;
            m_dev_addr <= '0;
            m_reg_addr <= '0;
            m_wr_data  <= '0;
        end else begin
            done <= '0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pick_vld) begin
                        win       <= pick;
                        cur_mode  <= mode_a[pick];
                        cur_dev   <= dev_a[pick];
                        cur_reg   <= reg_a[pick];
                        cur_wdata <= wdata_a[pick];
                        state     <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (MODE_IS_LEGAL(cur_mode)) begin
                        gnt        <= win_oh;
                        m_config   <= cur_mode;
                        m_dev_addr <= cur_dev;
                        m_reg_addr <= cur_reg;
                        m_wr_data  <= cur_wdata;
                        tmo_cnt    <= '0;
                        armed      <= 1'b0;
                        state      <= S_RUN;
                    end else begin
                        // Illegal mode: answer immediately, never touch the bus.
                        done    <= win_oh;
                        err     <= 1'b1;
                        rdata   <= '0;
                        gap_cnt <= '0;
                        state   <= S_GAP;
                    end
                end
                S_RUN: begin
                    if (!mdone_s) armed <= 1'b1;
                    if (hit || tmo) begin
                        done     <= gnt;
                        err      <= ~hit;
                        rdata    <= (hit && MODE_IS_READ(cur_mode)) ? m_rd_data : 8'h00;
                        gnt      <= '0;
                        m_config <= I2C_WAIT;
                        gap_cnt  <= '0;
                        state    <= S_GAP;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GW'(GAP_CYC - 1)) begin
                        ptr   <= (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed bench for the I2C request arbiter; completions are checked against a
// scoreboard of expected (requester, err, rdata) filled as each request is posted.
module tb_i2c_req_arbiter;

    localparam int NREQ = 4;
    localparam int TMO  = 1000;
    localparam int GAP  = 12;

    logic              clk_12m = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_mode, req_reg, req_wdata;
    logic [7*NREQ-1:0] req_dev;
    logic [NREQ-1:0]   gnt, done;
    logic              err, busy, m_done;
    logic [7:0]        rdata, m_config, m_reg_addr, m_wr_data, m_rd_data;
    logic [6:0]        m_dev_addr;

    always #5 clk_12m = ~clk_12m;

    i2c_req_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TMO), .GAP_CYC(GAP)) dut (
        .clk_12m(clk_12m), .rst_n(rst_n), .req(req), .req_mode(req_mode),
        .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata),
        .gnt(gnt), .done(done), .err(err), .rdata(rdata), .busy(busy),
        .m_config(m_config), .m_dev_addr(m_dev_addr), .m_reg_addr(m_reg_addr),
        .m_wr_data(m_wr_data), .m_rd_data(m_rd_data), .m_done(m_done)
    );

    typedef struct packed {
        logic [NREQ-1:0] who;
        logic            err;
        logic [7:0]      rdata;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   vec = 0;
    int   bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard pop on every completion pulse.
    always @(negedge clk_12m) begin
        if (rst_n && done != '0) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'h0);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_done_who", 32'(done), 32'(mon_e.who));
                chk("sb_done_err", 32'(err), 32'(mon_e.err));
                chk("sb_done_rdata", 32'(rdata), 32'(mon_e.rdata));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_12m);
    endtask

    task automatic set_req(input int i, input logic [7:0] mode, input logic [6:0] dev,
                           input logic [7:0] rg, input logic [7:0] wd);
        req_mode[8*i +: 8]  = mode;
        req_dev[7*i +: 7]   = dev;
        req_reg[8*i +: 8]   = rg;
        req_wdata[8*i +: 8] = wd;
        req[i]              = 1'b1;
    endtask

    task automatic push(input logic [NREQ-1:0] who, input logic e, input logic [7:0] rd);
        exp_t x;
        x.who   = who;
        x.err   = e;
        x.rdata = rd;
        sb.push_back(x);
    endtask

    task automatic wait_gnt(input string tag, output logic [NREQ-1:0] g);
        g = '0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_12m);
            if (gnt != '0) begin
                g = gnt;
                return;
            end
        end
        chk({tag, "_gnt_timeout"}, 32'h0, 32'h1);
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_12m);
            if (done != '0) return;
        end
        chk({tag, "_done_timeout"}, 32'h0, 32'h1);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_12m);
            if (!busy) return;
        end
        chk({tag, "_idle_timeout"}, 32'h0, 32'h1);
    endtask

    logic [NREQ-1:0] g;
    logic [7:0]      rd_tab [NREQ];
    logic            early;

    initial begin
        rd_tab[0] = 8'hA5; rd_tab[1] = 8'h5A; rd_tab[2] = 8'h3C; rd_tab[3] = 8'hC3;
        rst_n = 1'b0; req = '0; req_mode = '0; req_dev = '0; req_reg = '0;
        req_wdata = '0; m_rd_data = '0; m_done = 1'b0;
        tick(3);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_cfg", 32'(m_config), 32'h0);
        chk("rst_rdata", 32'(rdata), 32'h0);
        rst_n = 1'b1;
        tick(2);

        // 1: single write transaction, latency and gap
        m_rd_data = 8'hEE;
        set_req(0, 8'h01, 7'h50, 8'h00, 8'h11);
        push(4'b0001, 1'b0, 8'h00);
        tick(1);
        chk("t1_cfg_t1", 32'(m_config), 32'h00);
        tick(1);
        chk("t1_cfg_t2", 32'(m_config), 32'h01);
        chk("t1_gnt", 32'(gnt), 32'h1);
        chk("t1_dev", 32'(m_dev_addr), 32'h50);
        chk("t1_wdata", 32'(m_wr_data), 32'h11);
        tick(300);
        m_done = 1'b1;
        wait_done("t1");
        req[0] = 1'b0; m_done = 1'b0;
        chk("t1_gap0_cfg", 32'(m_config), 32'h00);
        chk("t1_gap0_busy", 32'(busy), 32'h1);
        tick(GAP - 1);
        chk("t1_gap_end_busy", 32'(busy), 32'h1);
        chk("t1_gap_end_cfg", 32'(m_config), 32'h00);
        tick(1);
        chk("t1_idle", 32'(busy), 32'h0);

        rst_n = 1'b0; tick(1); rst_n = 1'b1; tick(1);

        // 2: round robin over all four readers, then restart at 0
        for (int i = 0; i < NREQ; i++) set_req(i, 8'h04, 7'(7'h20 + i), 8'(i), 8'h00);
        for (int i = 0; i < NREQ; i++) begin
            wait_gnt("t2", g);
            chk("t2_order", 32'(g), 32'(1 << i));
            m_rd_data = rd_tab[i];
            push(4'(1 << i), 1'b0, rd_tab[i]);
            tick(20);
            m_done = 1'b1;
            wait_done("t2");
            req[i] = 1'b0; m_done = 1'b0;
        end
        req = 4'b1111;
        wait_gnt("t2r", g);
        chk("t2_restart", 32'(g), 32'h1);
        m_rd_data = 8'h66;
        push(4'b0001, 1'b0, 8'h66);
        tick(20);
        m_done = 1'b1;
        wait_done("t2r");
        req = '0; m_done = 1'b0;
        wait_idle("t2r");

        // 4: master never completes -> timeout (pointer now 1)
        set_req(1, 8'h01, 7'h21, 8'h10, 8'h33);
        push(4'b0010, 1'b1, 8'h00);
        wait_gnt("t4", g);
        chk("t4_gnt", 32'(g), 32'h2);
        tick(TMO - 1);
        chk("t4_pre_tmo", 32'(done), 32'h0);
        tick(1);
        chk("t4_tmo_done", 32'(done), 32'h2);
        chk("t4_tmo_err", 32'(err), 32'h1);
        req[1] = 1'b0;
        wait_idle("t4");

        // 5: stale-high m_done must not complete
        m_rd_data = 8'h11;
        m_done = 1'b1;
        tick(5);
        set_req(3, 8'h05, 7'h23, 8'h40, 8'h00);
        push(4'b1000, 1'b0, 8'h77);
        wait_gnt("t5", g);
        chk("t5_gnt", 32'(g), 32'h8);
        early = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (done != '0) early = 1'b1;
        end
        chk("t5_no_stale_done", 32'(early), 32'h0);
        m_done = 1'b0;
        tick(10);
        m_rd_data = 8'h77;
        m_done = 1'b1;
        wait_done("t5");
        chk("t5_done", 32'(done), 32'h8);
        req[3] = 1'b0; m_done = 1'b0;
        wait_idle("t5");

        // 3: illegal mode, bus untouched, answered two cycles after req
        set_req(2, 8'h07, 7'h22, 8'h00, 8'h00);
        push(4'b0100, 1'b1, 8'h00);
        tick(1);
        chk("t3_done_t1", 32'(done), 32'h0);
        tick(1);
        chk("t3_done_t2", 32'(done), 32'h4);
        chk("t3_err", 32'(err), 32'h1);
        chk("t3_cfg", 32'(m_config), 32'h00);
        chk("t3_gnt", 32'(gnt), 32'h0);
        req[2] = 1'b0;
        wait_idle("t3");

        // 6: reset mid-RUN (pointer was 3) then arbitration restarts from 0
        set_req(0, 8'h04, 7'h30, 8'h01, 8'h00);
        wait_gnt("t6", g);
        chk("t6_gnt", 32'(g), 32'h1);
        tick(5);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_gnt", 32'(gnt), 32'h0);
        chk("t6_rst_busy", 32'(busy), 32'h0);
        chk("t6_rst_cfg", 32'(m_config), 32'h00);
        chk("t6_rst_dev", 32'(m_dev_addr), 32'h00);
        tick(1);
        req = '0; rst_n = 1'b1;
        tick(2);
        set_req(1, 8'h04, 7'h31, 8'h02, 8'h00);
        set_req(3, 8'h04, 7'h33, 8'h03, 8'h00);
        m_rd_data = 8'h99;
        push(4'b0010, 1'b0, 8'h99);
        wait_gnt("t6b", g);
        chk("t6_ptr0", 32'(g), 32'h2);
        tick(10);
        m_done = 1'b1;
        wait_done("t6b");
        req = '0; m_done = 1'b0;
        wait_idle("t6b");

        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule
